// File: rtl/fifo_stream_writer.sv
// ---------------------------------------------------------------------------
// fifo_stream_writer
//
// Write-side producer for the 8x24-bit async FIFO, living in the w_clk domain.
// Accepts a valid/ready word stream with frame delimiters, buffers it in a
// two-entry skid pipeline (output register + skid register), and drives the
// FIFO write port. It honours 'full' without dropping or duplicating words.
//
// Optional feature macro: FIFO_WR_TRAILER_EN
//   When defined, a trailer word {8'hA5, seq[3:0], word_cnt[11:0]} is appended
//   after every frame and frame_done follows the trailer write. When undefined,
//   the stream carries only upstream words and frame_done follows the write of
//   the s_last data word.
//
// Ports
//   w_clk       in   write-domain clock (FIFO write clock)
//   w_rst_n     in   synchronous active-low reset
//   s_valid     in   upstream word valid
//   s_ready     out  block accepts the upstream word this cycle (registered)
//   s_data      in   upstream word [23:0]
//   s_last      in   final word of a frame
//   full        in   FIFO full flag
//   w_enable    out  FIFO write request (registered)
//   w_data      out  FIFO write data [23:0] (registered)
//   frame_done  out  one-cycle pulse after the last word of a frame is written
// ---------------------------------------------------------------------------
module fifo_stream_writer #(
    parameter int CNT_W = 12,
    parameter int SEQ_W = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_last,
    input  logic        full,
    output logic        w_enable,
    output logic [23:0] w_data,
    output logic        frame_done
);

    logic        wEnable_q, wEnable_d;
    logic [23:0] wData_q, wData_d;
    logic        outLast_q, outLast_d;
    logic        skidValid_q, skidValid_d;
    logic [23:0] skidData_q, skidData_d;
    logic        skidLast_q, skidLast_d;
    logic        sReady_q, sReady_d;
    logic        frameDone_q, frameDone_d;

    logic        transfer;
    logic        outFree;
    logic        accept;
    logic        enqValid;
    logic [23:0] enqData;
    logic        enqLast;

    // Counter widths only shape the trailer fields; a zero width is meaningless.
    if (CNT_W < 1 || SEQ_W < 1) begin : gBadWidths
    end

    assign transfer = wEnable_q && !full;
    assign outFree  = !wEnable_q || transfer;
    assign accept   = s_valid && sReady_q;

`ifdef FIFO_WR_TRAILER_EN
    localparam logic [0:0] ST_DATA  = 1'b0;
    localparam logic [0:0] ST_TRAIL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             trailerEnq;

    // The trailer may only enter once the skid register has drained, so it can
    // never overtake a data word still waiting there.
    assign trailerEnq = (state_q == ST_TRAIL) && !skidValid_q;
    assign enqValid   = accept || trailerEnq;
    assign enqData    = trailerEnq ? {8'hA5, seq_q, wordCnt_q} : s_data;
    assign enqLast    = trailerEnq;

    // Frame FSM: count accepted words (saturating), then emit one trailer.
    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        seq_d     = seq_q;
        if (state_q == ST_DATA) begin
            if (accept) begin
                if (wordCnt_q != '1) begin
                    wordCnt_d = wordCnt_q + CNT_W'(1);
                end
                if (s_last) begin
                    state_d = ST_TRAIL;
                end
            end
        end else if (trailerEnq) begin
            state_d   = ST_DATA;
            wordCnt_d = '0;
            seq_d     = seq_q + SEQ_W'(1);
        end
    end

    assign sReady_d = (state_d == ST_DATA) && !skidValid_d;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q   <= ST_DATA;
            wordCnt_q <= '0;
            seq_q     <= '0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            seq_q     <= seq_d;
        end
    end
`else
    assign enqValid = accept;
    assign enqData  = s_data;
    assign enqLast  = s_last;
    assign sReady_d = !skidValid_d;
`endif

    // Two-entry pipeline. The output register refills from the skid first so
    // ordering is kept; a new word only lands in the skid when the output
    // register is busy and not transferring this edge.
    always_comb begin
        wEnable_d   = wEnable_q;
        wData_d     = wData_q;
        outLast_d   = outLast_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        skidLast_d  = skidLast_q;
        if (outFree) begin
            if (skidValid_q) begin
                wEnable_d   = 1'b1;
                wData_d     = skidData_q;
                outLast_d   = skidLast_q;
                skidValid_d = 1'b0;
            end else if (enqValid) begin
                wEnable_d = 1'b1;
                wData_d   = enqData;
                outLast_d = enqLast;
            end else begin
                wEnable_d = 1'b0;
            end
        end else if (enqValid) begin
            skidValid_d = 1'b1;
            skidData_d  = enqData;
            skidLast_d  = enqLast;
        end
        frameDone_d = transfer && outLast_q;
    end

    // s_ready is kept as its own flop so it reads 0 while reset is held.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            wEnable_q   <= 1'b0;
            wData_q     <= '0;
            outLast_q   <= 1'b0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
            skidLast_q  <= 1'b0;
            sReady_q    <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            wEnable_q   <= wEnable_d;
            wData_q     <= wData_d;
            outLast_q   <= outLast_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            skidLast_q  <= skidLast_d;
            sReady_q    <= sReady_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign s_ready    = sReady_q;
    assign w_enable   = wEnable_q;
    assign w_data     = wData_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_fifo_stream_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_writer
//
// Directed bench for fifo_stream_writer. Expected streams follow the build:
// with FIFO_WR_TRAILER_EN defined a trailer follows each frame.
// ---------------------------------------------------------------------------
module tb_fifo_stream_writer;

`ifdef FIFO_WR_TRAILER_EN
    localparam bit TRAILER = 1'b1;
`else
    localparam bit TRAILER = 1'b0;
`endif

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        full = 1'b0;
    logic        w_enable;
    logic [23:0] w_data;
    logic        frame_done;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    logic [23:0] got[$];
    int          fdPos[$];

    fifo_stream_writer dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .full       (full),
        .w_enable   (w_enable),
        .w_data     (w_data),
        .frame_done (frame_done)
    );

    // Free-running 100 MHz write clock.
    always #5 w_clk = ~w_clk;

    // Cycle counter used to measure upstream throughput.
    always @(posedge w_clk) cycle = cycle + 1;

    // Record every word the FIFO will store on the coming edge, and the stream
    // position at which each frame_done pulse is seen.
    always @(negedge w_clk) begin
        if (frame_done) fdPos.push_back(got.size());
        if (w_rst_n && w_enable && !full) got.push_back(w_data);
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset();
        w_rst_n = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        full    = 1'b0;
        repeat (2) @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;
        got.delete();
        fdPos.delete();
    endtask

    task automatic pushWord(input logic [23:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge w_clk);
            ok = s_ready;
            @(posedge w_clk);
            #1;
        end
        s_valid = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL accept: got no accept of %h, want accept within 100 cycles", d);
        end
    endtask

    task automatic waitDrain(input int n, input int budget);
        int i;
        i = 0;
        while ((got.size() < n || w_enable) && i < budget) begin
            @(posedge w_clk);
            #1;
            i++;
        end
        repeat (3) @(posedge w_clk);
        #1;
        compared++;
        if (got.size() != n) begin
            mismatched++;
            $display("[TB] FAIL drain_count: got %0d words, want %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        s_valid = 1'b0;
        full    = 1'b0;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        compared++;
        if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_s_ready: got %b, want 0", s_ready); end
        compared++;
        if (w_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_w_enable: got %b, want 0", w_enable); end
        compared++;
        if (w_data !== 24'h000000) begin mismatched++; $display("[TB] FAIL rst_w_data: got %h, want 000000", w_data); end
        compared++;
        if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_frame_done: got %b, want 0", frame_done); end
        @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        @(posedge w_clk);
        @(negedge w_clk);
        compared++;
        if (s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_release_ready: got %b, want 1", s_ready); end
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_single_word();
        logic [23:0] exp[$];
        int          expFd;
        applyReset();
        pushWord(24'h000001, 1'b1);
        @(negedge w_clk);
        compared++;
        if (w_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL latency_wen: got %b, want 1", w_enable); end
        compared++;
        if (w_data !== 24'h000001) begin mismatched++; $display("[TB] FAIL latency_data: got %h, want 000001", w_data); end
        exp.push_back(24'h000001);
        if (TRAILER) exp.push_back(24'hA50001);
        expFd = exp.size();
        waitDrain(exp.size(), 50);
        for (int i = 0; i < exp.size(); i++) begin
            logic [23:0] g;
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== exp[i]) begin mismatched++; $display("[TB] FAIL single_stream[%0d]: got %h, want %h", i, g, exp[i]); end
        end
        compared++;
        if (fdPos.size() != 1) begin mismatched++; $display("[TB] FAIL single_fd_count: got %0d, want 1", fdPos.size()); end
        compared++;
        if (fdPos.size() < 1 || fdPos[0] != expFd) begin
            mismatched++;
            $display("[TB] FAIL single_fd_pos: got %0d, want %0d", (fdPos.size() > 0) ? fdPos[0] : -1, expFd);
        end
    endtask

    task automatic test_multi_frame();
        logic [23:0] exp[$];
        int          expFd[$];
        applyReset();
        pushWord(24'h111111, 1'b0);
        pushWord(24'h222222, 1'b0);
        pushWord(24'h333333, 1'b1);
        pushWord(24'h444444, 1'b1);
        exp.push_back(24'h111111);
        exp.push_back(24'h222222);
        exp.push_back(24'h333333);
        if (TRAILER) exp.push_back(24'hA50003);
        expFd.push_back(exp.size());
        exp.push_back(24'h444444);
        if (TRAILER) exp.push_back(24'hA51001);
        expFd.push_back(exp.size());
        waitDrain(exp.size(), 50);
        for (int i = 0; i < exp.size(); i++) begin
            logic [23:0] g;
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== exp[i]) begin mismatched++; $display("[TB] FAIL multi_stream[%0d]: got %h, want %h", i, g, exp[i]); end
        end
        for (int k = 0; k < 2; k++) begin
            int f;
            f = (k < fdPos.size()) ? fdPos[k] : -1;
            compared++;
            if (f != expFd[k]) begin mismatched++; $display("[TB] FAIL multi_fd_pos[%0d]: got %0d, want %0d", k, f, expFd[k]); end
        end
    endtask

    task automatic test_stall();
        logic [23:0] exp[$];
        applyReset();
        fork
            begin
                for (int i = 1; i <= 6; i++) pushWord(24'h600000 + 24'(i), i == 6);
            end
            begin
                repeat (2) @(posedge w_clk);
                #1 full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge w_clk);
                    compared++;
                    if (w_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_wen[%0d]: got %b, want 1", k, w_enable); end
                    compared++;
                    if (w_data !== 24'h600002) begin mismatched++; $display("[TB] FAIL stall_data[%0d]: got %h, want 600002", k, w_data); end
                    compared++;
                    if (s_ready !== (k == 0)) begin mismatched++; $display("[TB] FAIL stall_ready[%0d]: got %b, want %b", k, s_ready, (k == 0)); end
                end
                @(posedge w_clk);
                #1 full = 1'b0;
            end
        join
        for (int i = 1; i <= 6; i++) exp.push_back(24'h600000 + 24'(i));
        if (TRAILER) exp.push_back(24'hA50006);
        waitDrain(exp.size(), 50);
        for (int i = 0; i < exp.size(); i++) begin
            logic [23:0] g;
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== exp[i]) begin mismatched++; $display("[TB] FAIL stall_stream[%0d]: got %h, want %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp[$];
        int          startCycle;
        int          spent;
        int          per;
        applyReset();
        per = TRAILER ? 3 : 2;
        startCycle = cycle;
        for (int f = 0; f < 17; f++) begin
            for (int w = 1; w <= 2; w++) pushWord(24'hB00000 + 24'(f * 16 + w), w == 2);
        end
        spent = cycle - startCycle;
        compared++;
        if (spent != (TRAILER ? 50 : 34)) begin
            mismatched++;
            $display("[TB] FAIL b2b_cycles: got %0d, want %0d", spent, TRAILER ? 50 : 34);
        end
        for (int f = 0; f < 17; f++) begin
            for (int w = 1; w <= 2; w++) exp.push_back(24'hB00000 + 24'(f * 16 + w));
            if (TRAILER) exp.push_back({8'hA5, 4'(f), 12'h002});
        end
        waitDrain(exp.size(), 50);
        for (int i = 0; i < exp.size(); i++) begin
            logic [23:0] g;
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== exp[i]) begin mismatched++; $display("[TB] FAIL b2b_stream[%0d]: got %h, want %h", i, g, exp[i]); end
        end
        compared++;
        if (fdPos.size() != 17) begin mismatched++; $display("[TB] FAIL b2b_fd_count: got %0d, want 17", fdPos.size()); end
        for (int f = 0; f < 17; f++) begin
            int p;
            p = (f < fdPos.size()) ? fdPos[f] : -1;
            compared++;
            if (p != (f + 1) * per) begin mismatched++; $display("[TB] FAIL b2b_fd_pos[%0d]: got %0d, want %0d", f, p, (f + 1) * per); end
        end
    endtask

    task automatic test_saturation();
        int          n;
        logic [23:0] lastExp;
        logic [23:0] g;
        applyReset();
        for (int i = 0; i < 5000; i++) pushWord(24'hC00000 + 24'(i), i == 4999);
        n = TRAILER ? 5001 : 5000;
        lastExp = TRAILER ? 24'hA50FFF : 24'hC01387;
        waitDrain(n, 50);
        for (int i = 0; i < 5000; i += 997) begin
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== 24'hC00000 + 24'(i)) begin mismatched++; $display("[TB] FAIL sat_word[%0d]: got %h, want %h", i, g, 24'hC00000 + 24'(i)); end
        end
        g = (got.size() > 0) ? got[got.size() - 1] : 24'hxxxxxx;
        compared++;
        if (g !== lastExp) begin mismatched++; $display("[TB] FAIL sat_last: got %h, want %h", g, lastExp); end
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] exp[$];
        applyReset();
        s_valid = 1'b1;
        s_data  = 24'hDEAD01;
        s_last  = 1'b0;
        @(posedge w_clk);
        #1;
        s_data = 24'hDEAD02;
        full   = 1'b1;
        @(posedge w_clk);
        #1;
        s_valid = 1'b0;
        w_rst_n = 1'b0;
        @(negedge w_clk);
        compared++;
        if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_skid_full: got %b, want 0", s_ready); end
        compared++;
        if (w_data !== 24'hDEAD01) begin mismatched++; $display("[TB] FAIL mid_pre_data: got %h, want dead01", w_data); end
        @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        full    = 1'b0;
        @(negedge w_clk);
        compared++;
        if (w_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_wen: got %b, want 0", w_enable); end
        compared++;
        if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_fd: got %b, want 0", frame_done); end
        @(posedge w_clk);
        #1;
        got.delete();
        fdPos.delete();
        pushWord(24'hE00001, 1'b0);
        pushWord(24'hE00002, 1'b0);
        pushWord(24'hE00003, 1'b1);
        exp.push_back(24'hE00001);
        exp.push_back(24'hE00002);
        exp.push_back(24'hE00003);
        if (TRAILER) exp.push_back(24'hA50003);
        waitDrain(exp.size(), 50);
        for (int i = 0; i < exp.size(); i++) begin
            logic [23:0] g;
            g = (i < got.size()) ? got[i] : 24'hxxxxxx;
            compared++;
            if (g !== exp[i]) begin mismatched++; $display("[TB] FAIL mid_stream[%0d]: got %h, want %h", i, g, exp[i]); end
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_word();
        test_multi_frame();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_stream_writer.md
# fifo_stream_writer

Write-side producer for the 8×24-bit async FIFO, in the `w_clk` domain. It accepts a valid/ready word stream with frame delimiters and buffers it in a two-entry skid pipeline. It drives the FIFO write port (`w_enable`, `w_data`) and honours `full` without ever dropping or duplicating a word. An optional trailer word carrying a frame sequence number and word count is appended after each frame.

## Interface
- `CNT_W`, default 12: width of the per-frame word counter, equal to the trailer count field. Fixed at 12 while the trailer is enabled.
- `SEQ_W`, default 4: width of the frame sequence counter. Fixed at 4 while the trailer is enabled.
- `w_clk`, in, 1: write-domain clock, the same clock as the FIFO write side.
- `w_rst_n`, in, 1: reset, synchronous, active-low; clock `w_clk`.
- `s_valid`, in, 1: upstream word valid.
- `s_ready`, out, 1: the block accepts the upstream word this cycle.
- `s_data`, in, 24: upstream word.
- `s_last`, in, 1: the word is the final word of a frame. Only meaningful while `s_valid` is high.
- `full`, in, 1: FIFO full flag, driven from the FIFO write side.
- `w_enable`, out, 1: FIFO write request. Registered.
- `w_data`, out, 24: FIFO write data. Registered.
- `frame_done`, out, 1: one-cycle pulse when the final word of a frame is written into the FIFO.

## Operation
- Terminology:
  - **Accept**: a rising edge where `s_valid && s_ready`.
  - **Transfer**: a rising edge where `w_enable && !full`. The FIFO stores `w_data` on that edge.
- Storage:
  - Output register `{w_enable, w_data, out_last}`.
  - Skid register `{skid_valid, skid_data, skid_last}`.
- Enqueue source: either the upstream word, or the trailer word in state TRAIL.
- Enqueue placement:
  - If the output register is empty, or transfers on this edge, and the skid register is empty, the word goes to the output register.
  - Otherwise it goes to the skid register.
- On a transfer, a valid skid entry moves to the output register.
- `w_enable` drops only on a transfer with nothing to refill. While `full` is high, `w_enable` and `w_data` hold unchanged.
- `s_ready = (state == DATA) && !skid_valid`. It is decoded from registers only, with no combinational path from `s_valid` or `full`.
- State machine:
  - **DATA**: upstream words are accepted. `word_cnt` increments on each accept and saturates at 4095. An accept with `s_last`=1 moves to TRAIL.
  - **TRAIL**: `s_ready`=0. The trailer `{8'hA5, seq[3:0], word_cnt[11:0]}` is enqueued at the first edge where enqueue is possible, and is marked last. On that edge the block returns to DATA, clears `word_cnt` to 0, and increments `seq` modulo 16.
- `word_cnt` counts every accepted word of the frame, including the `s_last` word. A 1-word frame gives count 1.
- `frame_done` pulses on the cycle after a transfer whose `out_last`=1.

## Timing
- Reset values: `s_ready`=0 during reset and 1 on the first cycle after release; `w_enable`=0; `w_data`=0; `frame_done`=0.
- Internal reset values: `state`=DATA, `word_cnt`=0, `seq`=0, skid empty.
- Reset asserted mid-frame discards all buffered words and any pending trailer. The next frame starts with `seq`=0 and count 0.
- Latency: a word accepted at edge N into an empty pipeline gives `w_enable`=1 after N and is written at N+1 if `full`=0.
- Throughput: one word per cycle while `full`=0, in steady state with no trailers.
- Trailer cost: each trailer costs exactly one upstream bubble cycle.
- `full` rises while both registers are valid: `s_ready` falls on the next cycle. No word is lost.
- Transfer and accept on the same edge with the skid register empty: the new word goes straight to the output register.
- `s_last` on a word held in the skid register: TRAIL is entered at accept time, and the trailer is enqueued only after the skid register drains.
- `s_valid` while `s_ready`=0 is ignored. The upstream must hold the word.

## Configuration
- `FIFO_WR_TRAILER_EN` defined:
  - TRAIL state, trailer word, `word_cnt` and `seq` are present.
  - `frame_done` follows the trailer transfer.
- `FIFO_WR_TRAILER_EN` undefined:
  - No TRAIL state, counters or trailer; `s_ready = !skid_valid`.
  - `out_last` is the word's own `s_last`, so `frame_done` follows the transfer of the `s_last` data word.
  - The FIFO stream contains only upstream words.

## Test plan
- Reset, then `s_valid`=1 with `s_data`=0x000001, `s_last`=1, `full`=0: `w_data` sequence is 0x000001, then 0xA50001. `frame_done` pulses once, one cycle after the trailer write.
- 3-word frame 0x111111, 0x222222, 0x333333, followed by a second 1-word frame: trailers 0xA50003 and then 0xA51001.
- Hold `full`=1 for 5 cycles in the middle of a 6-word frame. Check that:
  - `w_enable`/`w_data` are stable throughout the stall;
  - `s_ready` is 0 once two words are buffered;
  - after release, all 6 words plus trailer 0xA5x006 arrive in order with no duplicates.
- Back-to-back frames 0–16: the `seq` field wraps 15 to 0 at frame 16, and exactly one bubble appears per frame.
- A 5000-word frame: the trailer count field saturates at 0xFFF.
- Assert `w_rst_n`=0 for one cycle mid-frame with the skid register full:
  - `w_enable`=0 and `frame_done`=0 immediately after;
  - the next frame's trailer is 0xA500nn.
